// File: rtl/fnd_display_scheduler_if.sv
// Bus between the display scheduler and its requesters / FND controller.
// The slave side is the scheduler; the master side drives requests and time sources.
interface fnd_display_scheduler_if;
  logic        tick_1khz;
  logic        i_src_sel;
  logic        i_view_next;
  logic        i_alert_req;
  logic [23:0] i_sw_data;
  logic [23:0] i_wt_data;
  logic [23:0] i_alert_data;
  logic [23:0] o_data;
  logic [1:0]  o_view;
  logic [1:0]  o_src;
  logic        o_blank;
  logic        o_alert_busy;
  logic        o_alert_ack;

  modport slave (
    input  tick_1khz, i_src_sel, i_view_next, i_alert_req,
    input  i_sw_data, i_wt_data, i_alert_data,
    output o_data, o_view, o_src, o_blank, o_alert_busy, o_alert_ack
  );

  modport master (
    output tick_1khz, i_src_sel, i_view_next, i_alert_req,
    output i_sw_data, i_wt_data, i_alert_data,
    input  o_data, o_view, o_src, o_blank, o_alert_busy, o_alert_ack
  );
endinterface

// File: rtl/fnd_display_scheduler.sv
// Chooses what the 4-digit FND shows: stopwatch or watch time, with a timed
// one-shot alert overlay followed by a blank gap before returning to the base source.
module fnd_display_scheduler #(
  parameter int          HOLD_MS    = 3000,
  parameter int          GAP_MS     = 200,
  parameter logic [1:0]  ALERT_VIEW = 2'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  fnd_display_scheduler_if.slave    bus
);

  localparam int CNT_MAX = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_MS == 0) ? '0 : CNT_W'(GAP_MS - 1);

  localparam logic [1:0] ST_BASE  = 2'd0;
  localparam logic [1:0] ST_ALERT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      alert_q, alert_d;
  logic [1:0]       view_q, view_d;
  logic             src_sel_q, src_sel_d;
  logic [23:0]      data_q, data_d;
  logic [1:0]       view_out_q, view_out_d;
  logic [1:0]       src_q, src_d;
  logic             blank_q, blank_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  // A request always wins over a terminal tick, whatever state we are in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alert_d = alert_q;
    ack_d   = 1'b0;
    if (bus.i_alert_req) begin
      state_d = ST_ALERT;
      cnt_d   = HOLD_LOAD;
      alert_d = bus.i_alert_data;
      ack_d   = 1'b1;
    end else if (bus.tick_1khz && state_q != ST_BASE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (state_q == ST_ALERT && GAP_MS != 0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end else begin
        state_d = ST_BASE;
      end
    end
  end

  // A source change restarts the base view even while an alert is up.
  always_comb begin
    src_sel_d = bus.i_src_sel;
    view_d    = view_q;
    if (bus.i_src_sel != src_sel_q) begin
      view_d = 2'd0;
    end else if (state_q == ST_BASE && !bus.i_alert_req && bus.i_view_next) begin
      view_d = (view_q == 2'd2) ? 2'd0 : view_q + 2'd1;
    end
  end

  always_comb begin
    data_d     = '0;
    view_out_d = ALERT_VIEW;
    src_d      = 2'b10;
    blank_d    = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      ST_ALERT: data_d = alert_d;
      ST_GAP:   blank_d = 1'b1;
      default: begin
        data_d     = bus.i_src_sel ? bus.i_wt_data : bus.i_sw_data;
        view_out_d = view_d;
        src_d      = {1'b0, bus.i_src_sel};
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BASE;
      cnt_q      <= '0;
      alert_q    <= '0;
      view_q     <= 2'd0;
      src_sel_q  <= 1'b0;
      data_q     <= '0;
      view_out_q <= 2'd0;
      src_q      <= 2'd0;
      blank_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alert_q    <= alert_d;
      view_q     <= view_d;
      src_sel_q  <= src_sel_d;
      data_q     <= data_d;
      view_out_q <= view_out_d;
      src_q      <= src_d;
      blank_q    <= blank_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_view       = view_out_q;
  assign bus.o_src        = src_q;
  assign bus.o_blank      = blank_q;
  assign bus.o_alert_busy = busy_q;
  assign bus.o_alert_ack  = ack_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Bench for fnd_display_scheduler with HOLD_MS=3, GAP_MS=2: directed scenarios
// with literal expectations plus a per-cycle comparison against a phase/ticks-left model.
module tb_fnd_display_scheduler;
  localparam int HOLD = 3;
  localparam int GAP  = 2;
  localparam logic [1:0] AVIEW = 2'd1;

  logic clk;
  logic reset;
  fnd_display_scheduler_if bus();

  fnd_display_scheduler #(.HOLD_MS(HOLD), .GAP_MS(GAP), .ALERT_VIEW(AVIEW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = base, 1 = alert, 2 = gap; m_left counts ticks still to go.
  int          m_phase, m_left, m_view, phase_before;
  logic [23:0] m_alert;
  logic        m_prev_src, src_changed;
  logic [23:0] e_data;
  logic [1:0]  e_view, e_src;
  logic        e_blank, e_busy, e_ack;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_left = 0; m_view = 0; m_alert = '0; m_prev_src = 1'b0;
      e_data = '0; e_view = 2'd0; e_src = 2'd0; e_blank = 0; e_busy = 0; e_ack = 0;
    end else begin
      phase_before = m_phase;
      src_changed  = (bus.i_src_sel != m_prev_src);
      m_prev_src   = bus.i_src_sel;
      e_ack = 0;
      if (bus.i_alert_req) begin
        m_phase = 1; m_left = HOLD; m_alert = bus.i_alert_data; e_ack = 1;
      end else if (bus.tick_1khz && m_phase != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_phase == 1 && GAP > 0) begin m_phase = 2; m_left = GAP; end
          else m_phase = 0;
        end
      end
      if (src_changed) m_view = 0;
      else if (phase_before == 0 && !bus.i_alert_req && bus.i_view_next) m_view = (m_view + 1) % 3;
      case (m_phase)
        0: begin
          e_data = bus.i_src_sel ? bus.i_wt_data : bus.i_sw_data;
          e_src = {1'b0, bus.i_src_sel}; e_view = 2'(m_view); e_blank = 0; e_busy = 0;
        end
        1: begin e_data = m_alert; e_src = 2'b10; e_view = AVIEW; e_blank = 0; e_busy = 1; end
        default: begin e_data = '0; e_src = 2'b10; e_view = AVIEW; e_blank = 1; e_busy = 1; end
      endcase
    end
    #2;
    vectors++;
    if (bus.o_data !== e_data || bus.o_view !== e_view || bus.o_src !== e_src ||
        bus.o_blank !== e_blank || bus.o_alert_busy !== e_busy || bus.o_alert_ack !== e_ack) begin
      miscompares++;
      $display("[TB] FAIL model_cycle t=%0t got data=%h view=%0d src=%0d blank=%0b busy=%0b ack=%0b want data=%h view=%0d src=%0d blank=%0b busy=%0b ack=%0b",
               $time, bus.o_data, bus.o_view, bus.o_src, bus.o_blank, bus.o_alert_busy, bus.o_alert_ack,
               e_data, e_view, e_src, e_blank, e_busy, e_ack);
    end
  end

  task automatic check_output(input string name, input logic [23:0] d, input logic [1:0] v,
                              input logic [1:0] s, input logic b, input logic bz, input logic ak);
    vectors++;
    if (bus.o_data !== d || bus.o_view !== v || bus.o_src !== s ||
        bus.o_blank !== b || bus.o_alert_busy !== bz || bus.o_alert_ack !== ak) begin
      miscompares++;
      $display("[TB] FAIL %s: got data=%h view=%0d src=%0d blank=%0b busy=%0b ack=%0b want data=%h view=%0d src=%0d blank=%0b busy=%0b ack=%0b",
               name, bus.o_data, bus.o_view, bus.o_src, bus.o_blank, bus.o_alert_busy, bus.o_alert_ack,
               d, v, s, b, bz, ak);
    end
  endtask

  task automatic check_after(input string name, input logic [23:0] d, input logic [1:0] v,
                             input logic [1:0] s, input logic b, input logic bz, input logic ak);
    @(posedge clk);
    #3;
    check_output(name, d, v, s, b, bz, ak);
  endtask

  task automatic apply_stimulus(input logic tk, input logic vn, input logic rq);
    @(negedge clk);
    bus.tick_1khz   = tk;
    bus.i_view_next = vn;
    bus.i_alert_req = rq;
  endtask

  initial begin
    reset = 1'b0;
    bus.tick_1khz = 0; bus.i_view_next = 0; bus.i_alert_req = 0; bus.i_src_sel = 0;
    bus.i_sw_data = 24'h12345; bus.i_wt_data = 24'h54321; bus.i_alert_data = 24'hABCDE;
    repeat (3) @(negedge clk);
    check_output("reset_state", 24'h0, 2'd0, 2'd0, 0, 0, 0);
    reset = 1'b1;

    apply_stimulus(0, 0, 0);
    check_after("base_stopwatch", 24'h12345, 2'd0, 2'd0, 0, 0, 0);
    apply_stimulus(0, 1, 0); check_after("view_01", 24'h12345, 2'd1, 2'd0, 0, 0, 0);
    apply_stimulus(0, 1, 0); check_after("view_10", 24'h12345, 2'd2, 2'd0, 0, 0, 0);
    apply_stimulus(0, 1, 0); check_after("view_wrap", 24'h12345, 2'd0, 2'd0, 0, 0, 0);
    apply_stimulus(0, 1, 0); check_after("view_prior", 24'h12345, 2'd1, 2'd0, 0, 0, 0);

    apply_stimulus(0, 0, 1); check_after("alert_accept", 24'hABCDE, AVIEW, 2'b10, 0, 1, 1);
    apply_stimulus(0, 1, 0); check_after("alert_ack_once", 24'hABCDE, AVIEW, 2'b10, 0, 1, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(1, 0, 0); check_after("alert_after_2_ticks", 24'hABCDE, AVIEW, 2'b10, 0, 1, 0);
    apply_stimulus(1, 0, 0); check_after("gap_entry", 24'h0, AVIEW, 2'b10, 1, 1, 0);
    apply_stimulus(1, 0, 0); check_after("gap_after_1_tick", 24'h0, AVIEW, 2'b10, 1, 1, 0);
    apply_stimulus(1, 0, 0); check_after("gap_exit", 24'h12345, 2'd1, 2'd0, 0, 0, 0);

    apply_stimulus(0, 0, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    bus.i_alert_data = 24'h13579;
    apply_stimulus(0, 0, 1); check_after("relatch", 24'h13579, AVIEW, 2'b10, 0, 1, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0); check_after("hold_restarted", 24'h13579, AVIEW, 2'b10, 0, 1, 0);
    apply_stimulus(1, 0, 0); check_after("relatch_gap", 24'h0, AVIEW, 2'b10, 1, 1, 0);

    apply_stimulus(1, 0, 0);
    bus.i_alert_data = 24'h2468A;
    apply_stimulus(1, 0, 1); check_after("req_beats_gap_end", 24'h2468A, AVIEW, 2'b10, 0, 1, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    bus.i_src_sel = 1'b1;
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0); check_after("src_change_in_gap", 24'h54321, 2'd0, 2'd1, 0, 0, 0);

    bus.i_src_sel = 1'b0;
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 1, 0); check_after("view_at_10", 24'h12345, 2'd2, 2'd0, 0, 0, 0);
    bus.i_src_sel = 1'b1;
    apply_stimulus(0, 1, 0); check_after("src_toggle_beats_view", 24'h54321, 2'd0, 2'd1, 0, 0, 0);

    bus.i_alert_data = 24'h0F0F0;
    apply_stimulus(0, 0, 1);
    apply_stimulus(1, 0, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    bus.i_src_sel = 1'b0;
    #1 check_output("async_reset_mid_alert", 24'h0, 2'd0, 2'd0, 0, 0, 0);
    apply_stimulus(0, 0, 0); check_after("reset_held", 24'h0, 2'd0, 2'd0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    check_after("release_to_stopwatch", 24'h12345, 2'd0, 2'd0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.tick_1khz    = ($urandom_range(3) == 0);
      bus.i_view_next  = ($urandom_range(5) == 0);
      bus.i_alert_req  = ($urandom_range(19) == 0);
      if ($urandom_range(24) == 0) bus.i_src_sel = ~bus.i_src_sel;
      bus.i_sw_data    = 24'($urandom);
      bus.i_wt_data    = 24'($urandom);
      bus.i_alert_data = 24'($urandom);
    end
    apply_stimulus(0, 0, 0);
    @(posedge clk); #4;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
